// File: rtl/ctl_enemy_fleet.sv
// Enemy formation controller: the whole fleet sweeps as one block, drops and reverses at
// the screen edges, loses members on hit, and respawns each cleared wave with a faster step.
module ctl_enemy_fleet #(
    parameter int N_ENEMY       = 4,
    parameter int XY_W          = 12,
    parameter int X_START       = 100,
    parameter int Y_START       = 50,
    parameter int SPACING       = 64,
    parameter int X_MIN         = 32,
    parameter int X_MAX         = 700,
    parameter int STEP          = 2,
    parameter int MAX_STEP      = 8,
    parameter int Y_DROP        = 16,
    parameter int Y_LIMIT       = 500,
    parameter int RESPAWN_TICKS = 60
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      run,
    input  logic [N_ENEMY-1:0]        hit,
    output logic [N_ENEMY*XY_W-1:0]   xpos_out,
    output logic [N_ENEMY*XY_W-1:0]   ypos_out,
    output logic [N_ENEMY-1:0]        on,
    output logic [3:0]                wave,
    output logic                      wave_clear,
    output logic                      game_over
);

    localparam int CW = XY_W + 2;
    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_MOVE_R,
        S_MOVE_L,
        S_CLEAR,
        S_HALT
    } state_t;

    state_t               state_reg, state_next;
    logic [XY_W-1:0]      fx_reg, fx_next;
    logic [XY_W-1:0]      fy_reg, fy_next;
    logic [N_ENEMY-1:0]   on_reg, on_next, on_hit;
    logic [3:0]           wave_reg, wave_next;
    logic                 wave_clear_reg, wave_clear_next;
    logic                 game_over_reg, game_over_next;
    logic [RW-1:0]        resp_reg, resp_next;

    logic [CW-1:0]        step_raw, cur_step, right_edge, left_limit, fy_drop;
    logic                 move, at_edge;
    logic [N_ENEMY*XY_W-1:0] xpos_next, ypos_next;
    logic [N_ENEMY*XY_W-1:0] xpos_reg, ypos_reg;

    // Edge arithmetic is done two bits wider than the coordinates so it can never wrap.
    assign step_raw   = CW'(STEP) + CW'(wave_reg);
    assign cur_step   = (step_raw > CW'(MAX_STEP)) ? CW'(MAX_STEP) : step_raw;
    assign right_edge = CW'(fx_reg) + CW'((N_ENEMY - 1) * SPACING) + cur_step;
    assign left_limit = CW'(X_MIN) + cur_step;
    assign fy_drop    = CW'(fy_reg) + CW'(Y_DROP);
    assign move       = tick && run;
    assign on_hit     = on_reg & ~hit;
    assign at_edge    = (state_reg == S_MOVE_R) ? (right_edge > CW'(X_MAX))
                                                : (CW'(fx_reg) < left_limit);

    always_comb begin
        state_next      = state_reg;
        fx_next         = fx_reg;
        fy_next         = fy_reg;
        on_next         = on_reg;
        wave_next       = wave_reg;
        wave_clear_next = 1'b0;
        game_over_next  = game_over_reg;
        resp_next       = resp_reg;
        case (state_reg)
            S_INIT: begin
                on_next    = '1;
                fx_next    = XY_W'(X_START);
                fy_next    = XY_W'(Y_START);
                state_next = S_MOVE_R;
            end
            S_MOVE_R, S_MOVE_L: begin
                on_next = on_hit;
                // Clearing the wave wins over any movement, drop or game-over in the same cycle.
                if ((on_reg != '0) && (on_hit == '0)) begin
                    wave_clear_next = 1'b1;
                    resp_next       = '0;
                    state_next      = S_CLEAR;
                end else if (move) begin
                    if (at_edge) begin
                        fy_next    = fy_drop[XY_W-1:0];
                        state_next = (state_reg == S_MOVE_R) ? S_MOVE_L : S_MOVE_R;
                        if (fy_drop >= CW'(Y_LIMIT)) begin
                            state_next     = S_HALT;
                            game_over_next = 1'b1;
                        end
                    end else if (state_reg == S_MOVE_R) begin
                        fx_next = fx_reg + cur_step[XY_W-1:0];
                    end else begin
                        fx_next = fx_reg - cur_step[XY_W-1:0];
                    end
                end
            end
            S_CLEAR: begin
                if (tick) begin
                    if (resp_reg == RW'(RESPAWN_TICKS - 1)) begin
                        resp_next  = '0;
                        wave_next  = (wave_reg == 4'd15) ? 4'd15 : wave_reg + 4'd1;
                        state_next = S_INIT;
                    end else begin
                        resp_next = resp_reg + RW'(1);
                    end
                end
            end
            S_HALT: begin
            end
            default: state_next = S_INIT;
        endcase
    end

    // Per-enemy coordinates are formed from the next origin so they land with the state update.
    generate
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_pos
            assign xpos_next[gi*XY_W +: XY_W] = fx_next + XY_W'(gi * SPACING);
            assign ypos_next[gi*XY_W +: XY_W] = fy_next;
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg      <= S_INIT;
            fx_reg         <= XY_W'(X_START);
            fy_reg         <= XY_W'(Y_START);
            on_reg         <= '0;
            wave_reg       <= '0;
            wave_clear_reg <= 1'b0;
            game_over_reg  <= 1'b0;
            resp_reg       <= '0;
            xpos_reg       <= xpos_next;
            ypos_reg       <= ypos_next;
            for (int i = 0; i < N_ENEMY; i++) begin
                xpos_reg[i*XY_W +: XY_W] <= XY_W'(X_START + i * SPACING);
                ypos_reg[i*XY_W +: XY_W] <= XY_W'(Y_START);
            end
        end else begin
            state_reg      <= state_next;
            fx_reg         <= fx_next;
            fy_reg         <= fy_next;
            on_reg         <= on_next;
            wave_reg       <= wave_next;
            wave_clear_reg <= wave_clear_next;
            game_over_reg  <= game_over_next;
            resp_reg       <= resp_next;
            xpos_reg       <= xpos_next;
            ypos_reg       <= ypos_next;
        end
    end

    assign xpos_out   = xpos_reg;
    assign ypos_out   = ypos_reg;
    assign on         = on_reg;
    assign wave       = wave_reg;
    assign wave_clear = wave_clear_reg;
    assign game_over  = game_over_reg;

endmodule

// File: doc/ctl_enemy_fleet.md
Name: ctl_enemy_fleet

Overview:
Parametrised successor to the single-enemy controller. Drives a formation of N_ENEMY enemies that move as one block: horizontal sweep, drop and reverse at the screen edges, per-enemy kill on hit, and wave respawn with step speed increasing each wave. Sits between the frame-tick generator and the enemy draw blocks. Packed x/y/on outputs feed one draw instance per enemy.

Parameters:
N_ENEMY, 4, number of enemies in the formation (1..16)
XY_W, 12, coordinate width
X_START, 100, fleet origin x at wave start
Y_START, 50, fleet origin y at wave start
SPACING, 64, x distance between adjacent enemies
X_MIN, 32, leftmost allowed x of enemy 0
X_MAX, 700, rightmost allowed x of enemy N_ENEMY-1
STEP, 2, pixels per tick in wave 0
MAX_STEP, 8, step saturation value
Y_DROP, 16, y increment at each edge reversal
Y_LIMIT, 500, fleet origin y at or beyond which the game is over
RESPAWN_TICKS, 60, ticks between wave clear and next wave

Ports:
pclk  input  1  pixel clock; the only clock
rst  input  1  synchronous, active-high reset
tick  input  1  one-cycle frame pulse; movement advances only on tick
run  input  1  1 = move on tick; 0 = freeze movement (hits still processed)
hit  input  N_ENEMY  per-enemy one-cycle kill pulse
xpos_out  output  N_ENEMY*XY_W  enemy i x at [i*XY_W +: XY_W], registered
ypos_out  output  N_ENEMY*XY_W  enemy i y at the same slicing (all equal fy), registered
on  output  N_ENEMY  enemy i alive/visible
wave  output  4  wave counter, saturates at 15
wave_clear  output  1  one-cycle pulse when the last alive enemy dies
game_over  output  1  sticky until rst

Behaviour:
- Internal fleet origin fx, fy (XY_W bits). Enemy i x = fx + i*SPACING, y = fy. Outputs are registered and reflect state one cycle after the update.
- Current step is cur_step = min(STEP + wave, MAX_STEP). Edge compares use XY_W+2 bits; no wrap-around.
- Reset (any cycle, including mid-wave or in HALT): state=INIT, fx=X_START, fy=Y_START, on=0, wave=0, wave_clear=0, game_over=0, respawn counter=0.
- INIT (1 cycle, no tick needed): on=all ones, fx=X_START, fy=Y_START, then MOVE_R.
- MOVE_R, on tick with run=1:
  - If fx+(N_ENEMY-1)*SPACING+cur_step > X_MAX: fy += Y_DROP, fx unchanged, go to MOVE_L.
  - Otherwise fx += cur_step.
- MOVE_L, on tick with run=1:
  - If fx < X_MIN+cur_step: fy += Y_DROP, fx unchanged, go to MOVE_R.
  - Otherwise fx -= cur_step.
- After any drop, if new fy >= Y_LIMIT: go to HALT and set game_over=1 in the same update. In HALT, positions and on are frozen and hits are ignored; HALT exits only on rst.
- Hits: hit[i] with on[i]=1 clears on[i] next cycle in INIT/MOVE_R/MOVE_L. hit[i] with on[i]=0 is ignored. Multiple bits in the same cycle are all applied. A hit and a tick in the same cycle are both applied.
- When on becomes all zero from a hit: wave_clear=1 for exactly one cycle and state goes to CLEAR. Clear takes precedence over a same-cycle drop and over the game_over check.
- CLEAR: positions frozen; counts ticks regardless of run. After RESPAWN_TICKS ticks: wave = min(wave+1, 15), then INIT.
- run=0 freezes movement and the edge logic only. The CLEAR tick count continues.

Test Plan:
- Reset: hold rst 2 cycles, release → on=0 during rst; one cycle later on=4'b1111, x = 100/164/228/292, y = 50 for all, wave=0, game_over=0.
- Sweep/reverse: 204 ticks → fx=508 (enemy 3 x=700); tick 205 → fx=508, fy=66, moving left; tick 206 → fx=506.
- Hits: hit=4'b0100 → on=4'b1011 next cycle. hit[2] again → no change. hit=4'b0001 together with a tick → on=4'b1010 and fx advances by 2 in the same update.
- Wave clear: kill all four, last two simultaneously → exactly one wave_clear pulse, positions frozen. After 60 ticks → INIT, wave=1, x restored to 100, per-tick step=3.
- Game over: force repeated edge reversals → after drop 29, fy=514 ≥ 500 → game_over=1, all outputs frozen, hits and ticks ignored until rst.
- Mid-wave reset and run gating: run=0 for 10 ticks → no movement. Assert rst in MOVE_L with wave=2 → all reset values restored, wave=0.
